seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_pkg.sv | 30 +++
 rtl/seq_alu_mul.sv | 57 +++++
 rtl/seq_alu.sv | 160 ++++++++++++++++
 tb/tb_seq_alu.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state type and flag payload for seq_alu.
// SEQ_ALU_MUL_EN adds the MUL state for the iterative multiplier.
package seq_alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_LSL = 4'b0011;
  localparam logic [3:0] OP_LSR = 4'b0100;
  localparam logic [3:0] OP_ASR = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_PSB = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_NOR = 4'b1100;

`ifdef SEQ_ALU_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;
`else
  typedef enum logic {S_IDLE, S_HOLD} state_t;
`endif

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
    logic op_err;
  } flags_t;

endpackage

// File: rtl/seq_alu_mul.sv
// Shift-add multiplier: low WIDTH bits of a*b, one partial product per cycle.
// The first partial is taken on the start edge; the last is exposed combinationally with done_c.
module seq_alu_mul #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_c,
  output logic [WIDTH-1:0] product_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] partial_c;

  // Accumulated sum including the current bit's partial product.
  always_comb begin
    partial_c = mplier_q[0] ? mcand_q : '0;
    product_c = acc_q + partial_c;
    done_c    = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= CNT_W'(1);
      acc_q    <= b[0] ? a : '0;
      mcand_q  <= a << 1;
      mplier_q <= b >> 1;
    end else if (busy_q) begin
      acc_q    <= product_c;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (done_c) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake, registered result and status flags.
// Define SEQ_ALU_MUL_EN to enable the iterative multiplier on opcode 1000.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [3:0]       alu_signal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             ZERO_FLAG,
  output logic             NEG_FLAG,
  output logic             CARRY_FLAG,
  output logic             OVF_FLAG,
  output logic             OP_ERR
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic             out_valid_d;
  logic [WIDTH-1:0] result_d;
  flags_t           flags_q, flags_d;
  logic             accept_c;
  logic [SH_W-1:0]  shamt_c;
  logic [WIDTH:0]   add_c;
  logic [WIDTH:0]   sub_c;
  logic [WIDTH-1:0] alu_res_c;
  flags_t           alu_flags_c;

`ifdef SEQ_ALU_MUL_EN
  logic             mul_start;
  logic             mul_done_c;
  logic [WIDTH-1:0] mul_product_c;

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start     (mul_start),
    .a         (data_a),
    .b         (data_b),
    .done_c    (mul_done_c),
    .product_c (mul_product_c)
  );
`endif

  assign in_ready   = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
  assign accept_c   = in_valid && in_ready;
  assign ZERO_FLAG  = flags_q.zero;
  assign NEG_FLAG   = flags_q.neg;
  assign CARRY_FLAG = flags_q.carry;
  assign OVF_FLAG   = flags_q.ovf;
  assign OP_ERR     = flags_q.op_err;

  // Single-cycle operations; SUB carry is the inverted borrow.
  always_comb begin
    shamt_c     = data_b[SH_W-1:0];
    add_c       = {1'b0, data_a} + {1'b0, data_b};
    sub_c       = {1'b0, data_a} + {1'b0, ~data_b} + (WIDTH + 1)'(1);
    alu_res_c   = '0;
    alu_flags_c = '0;
    case (alu_signal)
      OP_AND: alu_res_c = data_a & data_b;
      OP_OR:  alu_res_c = data_a | data_b;
      OP_NOR: alu_res_c = ~(data_a | data_b);
      OP_PSB: alu_res_c = data_b;
      OP_LSL: alu_res_c = data_a << shamt_c;
      OP_LSR: alu_res_c = data_a >> shamt_c;
      OP_ASR: alu_res_c = $signed(data_a) >>> shamt_c;
      OP_ADD: begin
        alu_res_c         = add_c[WIDTH-1:0];
        alu_flags_c.carry = add_c[WIDTH];
        alu_flags_c.ovf   = (data_a[WIDTH-1] == data_b[WIDTH-1]) &&
                            (add_c[WIDTH-1] != data_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_c         = sub_c[WIDTH-1:0];
        alu_flags_c.carry = sub_c[WIDTH];
        alu_flags_c.ovf   = (data_a[WIDTH-1] != data_b[WIDTH-1]) &&
                            (sub_c[WIDTH-1] != data_a[WIDTH-1]);
      end
`ifdef SEQ_ALU_MUL_EN
      OP_MUL: alu_res_c = '0;
`endif
      default: alu_flags_c.op_err = 1'b1;
    endcase
    alu_flags_c.zero = (alu_res_c == '0);
    alu_flags_c.neg  = alu_res_c[WIDTH-1];
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid;
    result_d    = alu_result;
    flags_d     = flags_q;
`ifdef SEQ_ALU_MUL_EN
    mul_start   = 1'b0;
`endif
    if (accept_c) begin
`ifdef SEQ_ALU_MUL_EN
      if (alu_signal == OP_MUL) begin
        state_d     = S_MUL;
        out_valid_d = 1'b0;
        mul_start   = 1'b1;
      end else
`endif
      begin
        state_d     = S_HOLD;
        out_valid_d = 1'b1;
        result_d    = alu_res_c;
        flags_d     = alu_flags_c;
      end
    end else begin
      case (state_q)
`ifdef SEQ_ALU_MUL_EN
        S_MUL: begin
          if (mul_done_c) begin
            state_d      = S_HOLD;
            out_valid_d  = 1'b1;
            result_d     = mul_product_c;
            flags_d      = '0;
            flags_d.zero = (mul_product_c == '0);
            flags_d.neg  = mul_product_c[WIDTH-1];
          end
        end
`endif
        S_HOLD: begin
          if (out_ready) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      out_valid  <= 1'b0;
      alu_result <= '0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      out_valid  <= out_valid_d;
      alu_result <= result_d;
      flags_q    <= flags_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed corner cases plus randomized ops against an arithmetic model.
// Expectations for opcode 1000 follow SEQ_ALU_MUL_EN.
module tb_seq_alu;

  localparam int unsigned W = 64;

  typedef struct packed {
    logic [W-1:0] res;
    logic z;
    logic n;
    logic c;
    logic v;
    logic e;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] data_a;
  logic [W-1:0] data_b;
  logic [3:0]   alu_signal;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_result;
  logic         ZERO_FLAG, NEG_FLAG, CARRY_FLAG, OVF_FLAG, OP_ERR;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_rdy = 1'b0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_a     (data_a),
    .data_b     (data_b),
    .alu_signal (alu_signal),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result),
    .ZERO_FLAG  (ZERO_FLAG),
    .NEG_FLAG   (NEG_FLAG),
    .CARRY_FLAG (CARRY_FLAG),
    .OVF_FLAG   (OVF_FLAG),
    .OP_ERR     (OP_ERR)
  );

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t       r;
    logic [5:0] sh;
    bit         sa, sb, sr;
    r  = '0;
    sh = b[5:0];
    case (op)
      4'b0000: r.res = a & b;
      4'b0001: r.res = a | b;
      4'b1100: r.res = ~(a | b);
      4'b0111: r.res = b;
      4'b0011: r.res = a << sh;
      4'b0100: r.res = a >> sh;
      4'b0101: r.res = $signed(a) >>> sh;
      4'b0010: begin
        r.res = a + b;
        r.c   = (r.res < a);
        sa = ($signed(a) < 0); sb = ($signed(b) < 0); sr = ($signed(r.res) < 0);
        r.v   = (sa == sb) && (sr != sa);
      end
      4'b0110: begin
        r.res = a - b;
        r.c   = (a >= b);
        sa = ($signed(a) < 0); sb = ($signed(b) < 0); sr = ($signed(r.res) < 0);
        r.v   = (sa != sb) && (sr != sa);
      end
`ifdef SEQ_ALU_MUL_EN
      4'b1000: r.res = a * b;
`endif
      default: r.e = 1'b1;
    endcase
    r.z = (r.res == '0);
    r.n = r.res[W-1];
    return r;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {1'b0, {(W-1){1'b1}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic exp_t mk(input logic [W-1:0] res, input logic z, input logic n,
                              input logic c, input logic v, input logic e);
    exp_t r;
    r = {res, z, n, c, v, e};
    return r;
  endfunction

  task automatic check_exp(input string name, input exp_t act, input exp_t exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got res=%h znvce=%b%b%b%b%b, expected res=%h znvce=%b%b%b%b%b", name,
               act.res, act.z, act.n, act.c, act.v, act.e,
               exp_v.res, exp_v.z, exp_v.n, exp_v.c, exp_v.v, exp_v.e);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp_v);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  function automatic exp_t dut_out();
    return mk(alu_result, ZERO_FLAG, NEG_FLAG, CARRY_FLAG, OVF_FLAG, OP_ERR);
  endfunction

  // Monitor: compare presented output against the oldest expectation; pop on handshake.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got res=%h with no pending expectation", alu_result);
        end else if (out_ready) begin
          check_exp("result", dut_out(), sb_q[0]);
          void'(sb_q.pop_front());
        end else begin
          check_exp("hold_stable", dut_out(), sb_q[0]);
          check_bit("hold_in_ready", in_ready, 1'b0);
        end
      end
    end
  end

  initial begin : ready_rand
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit use_exp, input exp_t exp_v, output int waits);
    int n;
    n = 0;
    in_valid = 1'b1;
    alu_signal = op;
    data_a = a;
    data_b = b;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    waits = n;
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles, required 1", n);
      in_valid = 1'b0;
      sync();
      return;
    end
    if (use_exp) sb_q.push_back(exp_v);
    else sb_q.push_back(model(op, a, b));
    sync();
    in_valid = 1'b0;
    data_a = {$urandom, $urandom};
    data_b = {$urandom, $urandom};
    alu_signal = 4'($urandom);
  endtask

  task automatic issue_m(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int w;
    issue(op, a, b, 1'b0, '0, w);
  endtask

  // Count cycles from acceptance to out_valid; in_ready must stay low while busy.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid) check_bit("busy_in_ready", in_ready, 1'b0);
    end while (!out_valid && lat < 200);
  endtask

  task automatic directed(input string name, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input exp_t exp_v, input int exp_lat);
    int w, lat;
    out_ready = 1'b1;
    issue(op, a, b, 1'b1, exp_v, w);
    wait_valid(lat);
    check_int(name, lat, exp_lat);
    sync();
  endtask

  localparam logic [W-1:0] MSB = {1'b1, {(W-1){1'b0}}};

  initial begin : stim
    logic [3:0] ops [11];
    int w, n, mul_lat;
    exp_t mul_exp;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100,
            4'b0011, 4'b0100, 4'b0101, 4'b1000, 4'b1111};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    data_a = '0; data_b = '0; alu_signal = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_exp("reset_outputs", dut_out(), '0);
    sync();
    rst = 1'b0;
    @(negedge clk);
    check_bit("in_ready_after_rst", in_ready, 1'b1);
    sync();

    directed("add_latency", 4'b0010, '1, 64'd1, mk('0, 1, 0, 1, 0, 0), 1);
    directed("sub_latency", 4'b0110, MSB, 64'd1, mk({1'b0, {(W-1){1'b1}}}, 0, 0, 1, 1, 0), 1);
    directed("asr_latency", 4'b0101, MSB, 64'h43, mk(64'hF000_0000_0000_0000, 0, 1, 0, 0, 0), 1);
    directed("lsl_latency", 4'b0011, 64'h1, 64'hFFFF_FFFF_FFFF_FF3F, mk(MSB, 0, 1, 0, 0, 0), 1);
`ifdef SEQ_ALU_MUL_EN
    mul_exp = mk(64'd5000, 0, 0, 0, 0, 0);
    mul_lat = 64;
`else
    mul_exp = mk('0, 1, 0, 0, 0, 1);
    mul_lat = 1;
`endif
    directed("mul_latency", 4'b1000, 64'd100, 64'd50, mul_exp, mul_lat);
    directed("undef_latency", 4'b1111, 64'h1234, 64'h5678, mk('0, 1, 0, 0, 0, 1), 1);

    // Stall in HOLD, then a back-to-back logic stream.
    out_ready = 1'b0;
    issue_m(4'b0010, pick(), pick());
    repeat (5) begin
      @(negedge clk);
      check_bit("stall_out_valid", out_valid, 1'b1);
    end
    sync();
    out_ready = 1'b1;
    issue(4'b0000, pick(), pick(), 1'b0, '0, w);
    check_int("stream_wait_and", w, 0);
    issue(4'b0001, pick(), pick(), 1'b0, '0, w);
    check_int("stream_wait_or", w, 0);
    issue(4'b1100, pick(), pick(), 1'b0, '0, w);
    check_int("stream_wait_nor", w, 0);
    @(negedge clk);
    check_bit("stream_last_valid", out_valid, 1'b1);
    sync();
    repeat (2) sync();

    // Abort a pending op with reset.
    out_ready = 1'b0;
    issue_m(4'b1000, 64'd100, 64'd50);
    repeat (10) sync();
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_bit("abort_out_valid", out_valid, 1'b0);
    check_exp("abort_outputs", dut_out(), '0);
    sync();
    rst = 1'b0;
    @(negedge clk);
    check_bit("abort_in_ready", in_ready, 1'b1);
    sync();

    // Randomized traffic with random back-pressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int k;
      logic [3:0] op;
      k = $urandom_range(0, 10);
      op = (k == 10) ? 4'($urandom) : ops[k];
      issue_m(op, pick(), pick());
      if ($urandom_range(0, 3) == 0) sync();
    end
    rand_rdy = 1'b0;
    sync();
    out_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      sync();
      n++;
    end
    check_int("drain_pending", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
